// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin arbiter that serializes the granted word MSB first
// onto a shift-cell chain, with an optional idle gap after each frame.
module shift_arb_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic             ser_out,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  sreg_r, sreg_s;
  logic [CW-1:0]     bit_cnt_r, bit_cnt_s;
  logic [3:0]        gap_cnt_r, gap_cnt_s;
  logic [1:0]        gnt_r, gnt_s;
  logic              sel_r, sel_s;
  logic              ser_r, ser_s;
  logic              owner_r, owner_s;
  logic              last_r, last_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              arb_ok_s;
  logic              pick_s;
  logic [WIDTH-1:0]  word_s;

  // Round-robin pick: on contention the requester that did not own last frame wins
  always_comb begin
    pick_s = 1'b0;
    case (req)
      2'b01:   pick_s = 1'b0;
      2'b10:   pick_s = 1'b1;
      2'b11:   pick_s = ~last_r;
      default: pick_s = 1'b0;
    endcase
    word_s = pick_s ? data1 : data0;
  end

  // Next-state and next-output logic; every output is computed here and registered below
  always_comb begin
    state_s   = state_r;
    sreg_s    = sreg_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    gnt_s     = 2'b00;
    sel_s     = 1'b0;
    ser_s     = 1'b0;
    owner_s   = owner_r;
    last_s    = last_r;
    done_s    = 1'b0;
    arb_ok_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        arb_ok_s = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt_r == BIT_LAST) begin
          done_s    = 1'b1;
          bit_cnt_s = '0;
          // Without a gap the end-of-frame edge doubles as the next arbitration edge
          if (GAP == 0) begin
            state_s  = ST_IDLE;
            arb_ok_s = 1'b1;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = 4'd0;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CW'(1);
          sel_s     = 1'b1;
          ser_s     = sreg_r[WIDTH-1];
          sreg_s    = {sreg_r[WIDTH-2:0], 1'b0};
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s   = ST_IDLE;
          gap_cnt_s = 4'd0;
          arb_ok_s  = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Grant: MSB goes out straight away, the rest waits in the shift register
    if (arb_ok_s && (req != 2'b00)) begin
      state_s   = ST_SHIFT;
      gnt_s     = pick_s ? 2'b10 : 2'b01;
      owner_s   = pick_s;
      last_s    = pick_s;
      sel_s     = 1'b1;
      ser_s     = word_s[WIDTH-1];
      sreg_s    = {word_s[WIDTH-2:0], 1'b0};
      bit_cnt_s = '0;
    end else begin
      gnt_s = 2'b00;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      sreg_r    <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= 4'd0;
      gnt_r     <= 2'b00;
      sel_r     <= 1'b0;
      ser_r     <= 1'b0;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      gnt_r     <= gnt_s;
      sel_r     <= sel_s;
      ser_r     <= ser_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign ser_out = ser_r;
  assign owner   = owner_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Scoreboard bench for shift_arb_ctrl: a GAP=1 instance checked by a frame
// monitor and a GAP=0 instance checked for back-to-back framing.
module tb_shift_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic [1:0] gnt;
  logic       sel, ser_out, owner, busy, done;

  logic [1:0] req_b = 2'b00;
  logic [7:0] data0_b = 8'h00, data1_b = 8'h00;
  logic [1:0] gnt_b;
  logic       sel_b, ser_b, owner_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic own; logic [7:0] word; } frame_t;
  frame_t exp_q[$];
  logic [7:0] exp_b_q[$];

  // monitor state
  logic       in_frame = 1'b0;
  logic       pending_done = 1'b0;
  logic [7:0] cur_word = 8'h00;
  int         bit_idx = 0;
  int         gnt_cnt = 0;
  int         idle_run = 0;
  int         last_run = 0;

  shift_arb_ctrl #(.WIDTH(8), .GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .sel(sel), .ser_out(ser_out), .owner(owner), .busy(busy), .done(done)
  );

  shift_arb_ctrl #(.WIDTH(8), .GAP(0)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data0(data0_b), .data1(data1_b),
    .gnt(gnt_b), .sel(sel_b), .ser_out(ser_b), .owner(owner_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mon_step();
    frame_t f;
    if (!rst_n) begin
      in_frame     = 1'b0;
      pending_done = 1'b0;
      idle_run     = 0;
    end else begin
      check_eq("done", done, pending_done);
      pending_done = 1'b0;
      if (gnt != 2'b00) begin
        gnt_cnt++;
        last_run = idle_run;
        if (exp_q.size() == 0) begin
          check_eq("unexp_gnt", gnt, 2'b00);
        end else begin
          f = exp_q.pop_front();
          check_eq("gnt", gnt, f.own ? 2'b10 : 2'b01);
          check_eq("owner", owner, f.own);
          cur_word = f.word;
          bit_idx  = 0;
          in_frame = 1'b1;
        end
      end
      check_eq("sel", sel, in_frame);
      if (in_frame) begin
        check_eq("ser", ser_out, cur_word[7-bit_idx]);
        bit_idx++;
        if (bit_idx == 8) begin
          in_frame     = 1'b0;
          pending_done = 1'b1;
        end
      end else begin
        check_eq("ser_idle", ser_out, 1'b0);
      end
      idle_run = sel ? 0 : idle_run + 1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 100 && gnt_cnt < target; i++) step();
    check_eq("gnt_wait", gnt_cnt >= target, 1'b1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !in_frame && !pending_done) break;
      step();
    end
    check_eq("drain", i < 60, 1'b1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int base;
    // reset state
    step();
    step();
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_sel", sel, 1'b0);
    check_eq("rst_ser", ser_out, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_owner", owner, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();
    check_eq("idle_gnt", gnt, 2'b00);

    // single requester 0, 0xA5
    exp_q.push_back('{1'b0, 8'hA5});
    data0 = 8'hA5;
    req   = 2'b01;
    step();
    check_eq("busy_shift", busy, 1'b1);
    req = 2'b00;
    repeat (8) step();
    check_eq("busy_gap", busy, 1'b1);
    check_eq("owner_a5", owner, 1'b0);
    step();
    check_eq("busy_idle", busy, 1'b0);
    drain();

    // contention after reset: 0,1,0 with one idle cycle between bursts
    do_reset();
    exp_q.push_back('{1'b0, 8'h0F});
    exp_q.push_back('{1'b1, 8'hF0});
    exp_q.push_back('{1'b0, 8'h0F});
    data0 = 8'h0F;
    data1 = 8'hF0;
    req   = 2'b11;
    base  = gnt_cnt;
    for (int g = 1; g <= 3; g++) begin
      wait_grants(base + g);
      if (g > 1) check_eq("gap_len", last_run, 1);
    end
    req = 2'b00;
    drain();

    // mid-frame req toggle and data change; held req re-granted with new data
    exp_q.push_back('{1'b0, 8'h3C});
    exp_q.push_back('{1'b0, 8'hC3});
    data0 = 8'h3C;
    req   = 2'b01;
    base  = gnt_cnt;
    wait_grants(base + 1);
    req   = 2'b00;
    data0 = 8'hFF;
    step();
    req   = 2'b01;
    data0 = 8'hC3;
    wait_grants(base + 2);
    req = 2'b00;
    drain();

    // reset mid-frame at bit 4, then contention goes to requester 0
    exp_q.push_back('{1'b0, 8'h9E});
    data0 = 8'h9E;
    req   = 2'b01;
    base  = gnt_cnt;
    wait_grants(base + 1);
    req = 2'b00;
    repeat (4) step();
    check_eq("pre_rst_sel", sel, 1'b1);
    check_eq("pre_rst_ser", ser_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_sel", sel, 1'b0);
    check_eq("arst_ser", ser_out, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_gnt", gnt, 2'b00);
    check_eq("arst_done", done, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back('{1'b0, 8'h11});
    data0 = 8'h11;
    data1 = 8'h22;
    req   = 2'b11;
    base  = gnt_cnt;
    wait_grants(base + 1);
    req = 2'b00;
    drain();

    // GAP=0 instance: requester 1 held, continuous sel, done coincides with gnt
    for (int f = 0; f < 4; f++) exp_b_q.push_back(8'hFF);
    data1_b = 8'hFF;
    req_b   = 2'b10;
    for (int i = 0; i < 10 && gnt_b == 2'b00; i++) step();
    check_eq("b_gnt_wait", gnt_b != 2'b00, 1'b1);
    for (int f = 0; f < 4; f++) begin
      logic [7:0] w;
      w = exp_b_q.pop_front();
      check_eq("b_gnt", gnt_b, 2'b10);
      check_eq("b_owner", owner_b, 1'b1);
      check_eq("b_done_coinc", done_b, f > 0);
      if (f == 3) req_b = 2'b00;
      for (int k = 0; k < 8; k++) begin
        check_eq("b_sel", sel_b, 1'b1);
        check_eq("b_ser", ser_b, w[7-k]);
        check_eq("b_busy", busy_b, 1'b1);
        if (k > 0) check_eq("b_gnt_mid", gnt_b, 2'b00);
        step();
      end
    end
    check_eq("b_done_last", done_b, 1'b1);
    check_eq("b_gnt_end", gnt_b, 2'b00);
    check_eq("b_sel_end", sel_b, 1'b0);
    check_eq("b_busy_end", busy_b, 1'b0);
    step();
    check_eq("b_done_once", done_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per serialized frame; legal range 2..32.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  2  per-requester frame request; bit i belongs to requester i; level-sensitive.
REQ-006 data0  input  WIDTH  requester 0 parallel word; held stable while req[0] high.
REQ-007 data1  input  WIDTH  requester 1 parallel word; held stable while req[1] high.
REQ-008 gnt  output  2  one-hot, one-cycle grant pulse; word captured.
REQ-009 sel  output  1  shift-cell load/shift enable; high exactly while a frame bit is valid on ser_out.
REQ-010 ser_out  output  1  serial data to shift cell chain, MSB first.
REQ-011 owner  output  1  index of requester owning current or last frame.
REQ-012 busy  output  1  high in SHIFT and GAP states.
REQ-013 done  output  1  one-cycle pulse after last bit of a frame.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 FSM SHALL have states IDLE, SHIFT, GAP.
REQ-016 IDLE with req==00: SHALL remain in IDLE; sel=0, gnt=00.
REQ-017 IDLE with any req bit high at edge E0: SHALL capture the selected word into a WIDTH-bit shift register, set gnt one-hot for the cycle after E0, set owner, load the bit counter with 0, enter SHIFT.
REQ-018 Arbitration: single requester wins; both requesting, the requester not equal to last owner wins (round-robin).
REQ-019 SHIFT: during the WIDTH cycles following E0, sel=1 and ser_out in cycle k (k=0..WIDTH-1) = captured word bit WIDTH-1-k.
REQ-020 After bit WIDTH-1: sel=0, ser_out=0, done=1 for exactly one cycle (cycle E0+WIDTH).
REQ-021 GAP>0: SHALL enter GAP for exactly GAP cycles, ignoring req, then IDLE; earliest next grant edge is E0+WIDTH+GAP.
REQ-022 GAP==0: SHALL return directly to IDLE arbitration at edge E0+WIDTH, so back-to-back frames produce continuous sel with no idle cycle; done and next gnt may coincide.
REQ-023 req changes during SHIFT/GAP SHALL NOT affect the frame in progress; data inputs SHALL be sampled only at the grant edge.
REQ-024 A req bit still high when IDLE is re-entered SHALL be treated as a new request (re-grant permitted subject to REQ-018).
REQ-025 Bit counter width SHALL be clog2(WIDTH+1); gap counter 4 bits; no wrap beyond terminal count.
REQ-026 busy SHALL be high from cycle E0+1 through the last GAP cycle, low in IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, gnt=00, sel=0, ser_out=0, done=0, busy=0, owner=0, counters 0, shift register 0.
REQ-028 Reset SHALL set last-owner pointer to 1 so requester 0 wins the first contention.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no done pulse; first grant after release follows REQ-017 from IDLE.

Verification
REQ-030 WIDTH=8, GAP=1, req=01, data0=0xA5 -> gnt=01 one cycle; sel high 8 cycles, ser_out 1,0,1,0,0,1,0,1; done one cycle; owner=0.
REQ-031 After reset, req=11, data0=0x0F, data1=0xF0, held -> frames alternate owner 0,1,0; ser_out patterns 0x0F,0xF0,0x0F; 1 idle cycle between sel bursts.
REQ-032 GAP=0, req=10 held, data1=0xFF -> sel continuously high across consecutive frames; done pulse coincides with next gnt=10 every 8 cycles.
REQ-033 rst_n pulsed low at bit 4 of a frame -> sel, ser_out, busy, gnt drop to 0 asynchronously; no done; next req=11 grants requester 0.
REQ-034 req[0] toggled and data0 changed mid-frame -> serialized bits equal word captured at grant edge; no extra gnt until IDLE.
